// File: rtl/tpu_job_ctrl.sv
// Job controller between the host operand stream and the TPU core: buffers k operand rows,
// feeds them to the core, captures m result rows and returns them to the host with backpressure.
module tpu_job_ctrl #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [LEN_W-1:0]  m,
  input  logic [LEN_W-1:0]  k,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic              core_out_valid,
  output logic              core_out_ready,
  input  logic [DATA_W-1:0] core_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  // One spare pointer bit keeps the terminal count DEPTH distinct from 0.
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, OUTPUT, DONE} state_t;
  state_t state;

  logic [PW-1:0]     wr_ptr, rd_ptr, cap_ptr, out_ptr;
  logic [PW-1:0]     m_eff, k_eff;
  logic [PW-1:0]     k_in, k_last, m_last, out_ptr_nxt;
  logic              in_fire, cap_fire;
  logic [DATA_W-1:0] a_buf [DEPTH];
  logic [DATA_W-1:0] b_buf [DEPTH];
  logic [DATA_W-1:0] o_buf [DEPTH];

  // Zero and anything beyond the buffer depth both mean a full-depth job.
  function automatic logic [PW-1:0] sat_len(input logic [LEN_W-1:0] len);
    if (len == '0 || 32'(len) > 32'(DEPTH))
      return PW'(DEPTH);
    return len[PW-1:0];
  endfunction

  assign in_fire     = in_valid & in_ready & ~abort;
  assign cap_fire    = core_out_valid & core_out_ready & ~abort;
  assign k_in        = sat_len(k);
  assign k_last      = k_eff - PW'(1);
  assign m_last      = m_eff - PW'(1);
  assign out_ptr_nxt = out_ptr + PW'(1);

  assign core_a   = core_in_valid ? a_buf[rd_ptr[AW-1:0]] : '0;
  assign core_b   = core_in_valid ? b_buf[rd_ptr[AW-1:0]] : '0;
  assign out_data = out_valid ? o_buf[out_ptr[AW-1:0]] : '0;

  // wr_ptr sits at 0 in IDLE, so the first beat lands in row 0 without a special case.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_buf[wr_ptr[AW-1:0]] <= a_data;
      b_buf[wr_ptr[AW-1:0]] <= b_data;
    end
    if (cap_fire)
      o_buf[cap_ptr[AW-1:0]] <= core_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cap_ptr        <= '0;
      out_ptr        <= '0;
      m_eff          <= '0;
      k_eff          <= '0;
      in_ready       <= 1'b1;
      core_in_valid  <= 1'b0;
      core_out_ready <= 1'b0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (abort) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cap_ptr        <= '0;
      out_ptr        <= '0;
      in_ready       <= 1'b1;
      core_in_valid  <= 1'b0;
      core_out_ready <= 1'b0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_fire) begin
          m_eff <= sat_len(m);
          k_eff <= k_in;
          busy  <= 1'b1;
          if (k_in == PW'(1)) begin
            state         <= FEED;
            in_ready      <= 1'b0;
            core_in_valid <= 1'b1;
          end else begin
            state  <= LOAD;
            wr_ptr <= PW'(1);
          end
        end
        LOAD: if (in_fire) begin
          wr_ptr <= wr_ptr + PW'(1);
          if (wr_ptr == k_last) begin
            state         <= FEED;
            in_ready      <= 1'b0;
            core_in_valid <= 1'b1;
          end
        end
        FEED: if (core_in_valid && core_in_ready) begin
          rd_ptr <= rd_ptr + PW'(1);
          if (rd_ptr == k_last) begin
            state          <= DRAIN;
            core_in_valid  <= 1'b0;
            core_out_ready <= 1'b1;
          end
        end
        DRAIN: if (cap_fire) begin
          cap_ptr <= cap_ptr + PW'(1);
          if (cap_ptr == m_last) begin
            state          <= OUTPUT;
            core_out_ready <= 1'b0;
            out_valid      <= 1'b1;
            out_ptr        <= '0;
            out_last       <= (m_last == '0);
          end
        end
        OUTPUT: if (out_valid && out_ready) begin
          out_ptr  <= out_ptr_nxt;
          out_last <= (out_ptr_nxt == m_last);
          if (out_last) begin
            state     <= DONE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          cap_ptr  <= '0;
          out_ptr  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_job_ctrl.sv
// Scoreboard bench for tpu_job_ctrl: host, core and sink models run cycle by cycle from one task.
module tb_tpu_job_ctrl;
  localparam int DATA_W = 256;
  localparam int DEPTH  = 32;
  localparam int LEN_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] a_data = '0;
  logic [DATA_W-1:0] b_data = '0;
  logic [LEN_W-1:0]  m = '0;
  logic [LEN_W-1:0]  k = '0;
  logic              core_in_valid;
  logic              core_in_ready = 1'b0;
  logic [DATA_W-1:0] core_a, core_b;
  logic              core_out_valid = 1'b0;
  logic              core_out_ready;
  logic [DATA_W-1:0] core_out = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy, done;

  tpu_job_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data), .m(m), .k(k),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_a(core_a), .core_b(core_b),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] fa_q[$], fb_q[$], res_q[$];
  int acc_cnt, fed_cnt, out_cnt, done_cnt;
  int first_acc_cyc, first_civ_cyc, first_out_cyc, last_out_cyc, out_valid_cycles;
  int done_cyc, last_beat_cyc;
  bit saw_low_pending, aborted, stopped;

  function automatic logic [DATA_W-1:0] rnd_row();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int dec_len(input int v);
    return (v == 0 || v > DEPTH) ? DEPTH : v;
  endfunction

  task automatic run_job(input int mm, input int kk, input int nb, input bit cstall,
                         input bit ostall, input bit early, input int lat,
                         input int abort_at, input bit stop_out);
    int k_exp, m_exp, res_sent, feed_end, start;
    bit closed, held, abort_now, exp_l;
    logic held_l;
    logic [DATA_W-1:0] cur_a, cur_b, cur_r, held_d, ea, eb, ed;
    k_exp = dec_len(kk);
    m_exp = dec_len(mm);
    res_sent = 0; feed_end = -1; start = cyc;
    closed = 0; held = 0; held_l = 1'b0; held_d = '0;
    fa_q.delete(); fb_q.delete(); res_q.delete();
    acc_cnt = 0; fed_cnt = 0; out_cnt = 0; done_cnt = 0;
    first_acc_cyc = -1; first_civ_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    out_valid_cycles = 0; done_cyc = -1; last_beat_cyc = -1;
    saw_low_pending = 0; aborted = 0; stopped = 0;
    cur_a = rnd_row(); cur_b = rnd_row(); cur_r = rnd_row();
    while (1) begin
      @(negedge clk);
      if (cyc - start > 3000) begin
        checks++; errors++;
        $display("FAIL timeout: job m=%0d k=%0d fed=%0d out=%0d, required completion", mm, kk, fed_cnt, out_cnt);
        break;
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b last=%0b data=%h, required valid=1 last=%0b data=%h",
                   out_valid, out_last, out_data, held_l, held_d);
        end
      end
      if (done === 1'b1) begin
        done_cnt++; done_cyc = cyc;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL done_gap: in_ready=%0b during done, required 0", in_ready);
        end
        in_valid = 1'b0; core_out_valid = 1'b0; core_out = '0; out_ready = 1'b0; core_in_ready = 1'b0;
        break;
      end
      // host operand source
      in_valid = (!closed && acc_cnt < nb);
      a_data = cur_a; b_data = cur_b;
      m = (acc_cnt == 0) ? LEN_W'(mm) : LEN_W'($urandom);
      k = (acc_cnt == 0) ? LEN_W'(kk) : LEN_W'($urandom);
      if (acc_cnt > 0 && in_ready !== 1'b1) begin
        if (in_valid) saw_low_pending = 1;
        closed = 1;
      end
      abort_now = (abort_at >= 0 && fed_cnt == abort_at && core_in_valid === 1'b1);
      abort = abort_now;
      if (in_valid && in_ready === 1'b1 && !abort_now) begin
        fa_q.push_back(cur_a); fb_q.push_back(cur_b);
        if (acc_cnt == 0) first_acc_cyc = cyc;
        acc_cnt++;
        cur_a = rnd_row(); cur_b = rnd_row();
      end
      // core operand sink
      if (core_in_valid === 1'b1 && first_civ_cyc < 0) first_civ_cyc = cyc;
      core_in_ready = cstall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!abort_now && core_in_valid === 1'b1 && core_in_ready) begin
        checks++;
        if (fa_q.size() == 0) begin
          errors++; $display("FAIL feed_extra: row %0d fed, required only %0d", fed_cnt, k_exp);
        end else begin
          ea = fa_q.pop_front(); eb = fb_q.pop_front();
          if (core_a !== ea || core_b !== eb) begin
            errors++; $display("FAIL feed_row %0d: core_a=%h, required %h (b match=%0b)", fed_cnt, core_a, ea, core_b === eb);
          end
        end
        fed_cnt++;
        if (fed_cnt == k_exp) feed_end = cyc;
      end
      // core result source
      core_out_valid = (res_sent < m_exp) && (early || (feed_end >= 0 && cyc >= feed_end + lat)) &&
                       (!cstall || $urandom_range(0, 1) == 1);
      core_out = core_out_valid ? cur_r : '0;
      if (core_out_ready === 1'b1) begin
        checks++;
        if (core_in_valid !== 1'b0) begin
          errors++; $display("FAIL drain_overlap: core_out_ready=1 with core_in_valid=%0b, required 0", core_in_valid);
        end
      end
      if (!abort_now && core_out_valid && core_out_ready === 1'b1) begin
        res_q.push_back(cur_r); res_sent++; cur_r = rnd_row();
      end
      // host result sink
      if (stop_out && out_valid === 1'b1 && out_cnt >= 1) begin
        out_ready = 1'b0; stopped = 1;
        break;
      end
      out_ready = ostall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid === 1'b1) begin
        out_valid_cycles++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
      held = 0;
      if (!abort_now && out_valid === 1'b1 && out_ready) begin
        checks++;
        exp_l = (out_cnt == m_exp - 1);
        if (res_q.size() == 0) begin
          errors++; $display("FAIL out_extra: beat %0d returned, required only %0d", out_cnt, m_exp);
        end else begin
          ed = res_q.pop_front();
          if (out_data !== ed || out_last !== exp_l) begin
            errors++; $display("FAIL out_beat %0d: last=%0b data=%h, required last=%0b data=%h", out_cnt, out_last, out_data, exp_l, ed);
          end
        end
        if (exp_l) last_beat_cyc = cyc;
        out_cnt++;
      end else if (out_valid === 1'b1) begin
        held = 1; held_d = out_data; held_l = out_last;
      end
      if (abort_now) begin
        aborted = 1;
        break;
      end
    end
    if (done_cnt == 1) begin
      checks++;
      if (fed_cnt != k_exp || out_cnt != m_exp || res_q.size() != 0 || fa_q.size() != 0) begin
        errors++; $display("FAIL job_counts: fed=%0d out=%0d left=%0d, required fed=%0d out=%0d left=0", fed_cnt, out_cnt, res_q.size(), k_exp, m_exp);
      end
      checks++;
      if (done_cyc != last_beat_cyc + 1) begin
        errors++; $display("FAIL done_timing: done at %0d, required %0d", done_cyc, last_beat_cyc + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, core_in_valid, core_out_ready, out_valid, out_last, busy, done} !== 7'b1000000) begin
      errors++; $display("FAIL reset_ctrl: flags=%b, required 1000000", {in_ready, core_in_valid, core_out_ready, out_valid, out_last, busy, done});
    end
    checks++;
    if (out_data !== '0 || core_a !== '0 || core_b !== '0) begin
      errors++; $display("FAIL reset_data: out_data=%h core_a=%h, required 0", out_data, core_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: in_ready=%0b busy=%0b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    run_job(4, 4, 4, 0, 0, 0, 3, -1, 0);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done: count=%0d, required 1", done_cnt); end
    checks++;
    if (out_valid_cycles != 4 || last_out_cyc - first_out_cyc != 3) begin
      errors++; $display("FAIL basic_out_run: valid cycles=%0d span=%0d, required 4 3", out_valid_cycles, last_out_cyc - first_out_cyc);
    end
  endtask

  task automatic test_full_depth();
    run_job(0, 40, 40, 0, 0, 0, 2, -1, 0);
    checks++;
    if (acc_cnt != DEPTH || saw_low_pending != 1'b1) begin
      errors++; $display("FAIL full_accept: accepted=%0d beat33_blocked=%0b, required %0d 1", acc_cnt, saw_low_pending, DEPTH);
    end
    checks++;
    if (out_cnt != DEPTH || done_cnt != 1) begin
      errors++; $display("FAIL full_results: out=%0d done=%0d, required %0d 1", out_cnt, done_cnt, DEPTH);
    end
  endtask

  task automatic test_backpressure();
    int mv[3] = '{12, 5, 32};
    int kv[3] = '{10, 20, 3};
    for (int i = 0; i < 3; i++) begin
      run_job(mv[i], kv[i], kv[i], 1, 1, 1, 1, -1, 0);
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL bp_done %0d: count=%0d, required 1", i, done_cnt); end
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    run_job(4, 8, 8, 0, 0, 0, 3, 2, 0);
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (aborted != 1'b1 || busy !== 1'b0 || core_in_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_state: aborted=%0b busy=%0b civ=%0b in_ready=%0b, required 1 0 0 1", aborted, busy, core_in_valid, in_ready);
    end
    saw_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
      @(negedge clk);
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_no_done: done/busy seen=1, required 0"); end
    run_job(1, 1, 1, 0, 0, 0, 2, -1, 0);
    checks++;
    if (done_cnt != 1 || out_cnt != 1) begin
      errors++; $display("FAIL abort_recover: done=%0d out=%0d, required 1 1", done_cnt, out_cnt);
    end
  endtask

  task automatic test_reset_mid_output();
    run_job(3, 2, 2, 0, 0, 0, 1, -1, 1);
    checks++;
    if (stopped != 1'b1) begin errors++; $display("FAIL rst_out_reach: stopped=%0b, required 1", stopped); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async: out_valid=%0b done=%0b busy=%0b data=%h, required 0 0 0 0", out_valid, done, busy, out_data);
    end
    in_valid = 1'b0; core_out_valid = 1'b0; core_out = '0; core_in_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_release: in_ready=%0b busy=%0b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    run_job(1, 1, 1, 0, 0, 0, 1, -1, 0);
    d1 = done_cyc;
    checks++;
    if (first_civ_cyc != first_acc_cyc + 1) begin
      errors++; $display("FAIL single_direct_feed: feed at %0d, required %0d", first_civ_cyc, first_acc_cyc + 1);
    end
    run_job(1, 1, 1, 0, 0, 0, 0, -1, 0);
    checks++;
    if (first_acc_cyc != d1 + 1 || first_civ_cyc != first_acc_cyc + 1 || done_cnt != 1) begin
      errors++; $display("FAIL b2b_gap: accept at %0d feed at %0d done=%0d, required %0d %0d 1", first_acc_cyc, first_civ_cyc, done_cnt, d1 + 1, d1 + 2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_backpressure();
    test_abort();
    test_reset_mid_output();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
